// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receiver/CPU register side (master) and the receive FIFO (slave).
// Optional UART_RX_FIFO_IRQ_EN adds the irq_thresh / irq pair.
interface uart_rx_fifo_if #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]  rx_data;
   logic              rx_done;
   logic              rd_en;
   logic              flush;
   logic              ovr_clr;
   logic [WIDTH-1:0]  rd_data;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   count;
   logic              overrun;
`ifdef UART_RX_FIFO_IRQ_EN
   logic [ADDR_W:0]   irq_thresh;
   logic              irq;
`endif

`ifdef UART_RX_FIFO_IRQ_EN
   modport master (
      output rx_data, rx_done, rd_en, flush, ovr_clr, irq_thresh,
      input  rd_data, empty, full, count, overrun, irq
   );
   modport slave (
      input  rx_data, rx_done, rd_en, flush, ovr_clr, irq_thresh,
      output rd_data, empty, full, count, overrun, irq
   );
`else
   modport master (
      output rx_data, rx_done, rd_en, flush, ovr_clr,
      input  rd_data, empty, full, count, overrun
   );
   modport slave (
      input  rx_data, rx_done, rd_en, flush, ovr_clr,
      output rd_data, empty, full, count, overrun
   );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: circular first-word-fall-through byte buffer with sticky overrun.
// Define UART_RX_FIFO_IRQ_EN to add a registered threshold/overrun interrupt.
module uart_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           nrst,
   uart_rx_fifo_if.slave  bus
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   cnt;
   logic              ovr;

   logic              is_empty;
   logic              is_full;
   logic              do_push;
   logic              do_pop;
   logic              ovr_set;
   logic [ADDR_W:0]   cnt_next;
   logic              ovr_next;

   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   always_comb begin
      is_empty = (cnt == '0);
      is_full  = (cnt == FULL_CNT);
      do_pop   = bus.rd_en && !is_empty;
      do_push  = bus.rx_done && (!is_full || do_pop);
      ovr_set  = bus.rx_done && is_full && !bus.rd_en && !bus.flush;
      ovr_next = ovr_set || (ovr && !bus.ovr_clr);
      cnt_next = cnt;
      if (bus.flush) begin
         cnt_next = '0;
      end else if (do_push && !do_pop) begin
         cnt_next = cnt + (ADDR_W+1)'(1);
      end else if (do_pop && !do_push) begin
         cnt_next = cnt - (ADDR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovr    <= 1'b0;
      end else begin
         cnt <= cnt_next;
         ovr <= ovr_next;
         if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push) begin
               wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_pop) begin
               rd_ptr <= rd_ptr + ADDR_W'(1);
            end
         end
      end
   end

   // Storage carries no reset; empty gating on rd_data hides stale contents.
   always_ff @(posedge clk) begin
      if (do_push && !bus.flush) begin
         mem[wr_ptr] <= bus.rx_data;
      end
   end

   assign bus.rd_data = is_empty ? '0 : mem[rd_ptr];
   assign bus.empty   = is_empty;
   assign bus.full    = is_full;
   assign bus.count   = cnt;
   assign bus.overrun = ovr;

`ifdef UART_RX_FIFO_IRQ_EN
   logic irq_q;
   logic irq_next;

   // Evaluated on next-state values so irq moves in the same cycle as count.
   always_comb begin
      irq_next = ((cnt_next >= bus.irq_thresh) && (bus.irq_thresh != '0)) || ovr_next;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_next;
      end
   end

   assign bus.irq = irq_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, WIDTH=8).
// The irq checks are compiled in when UART_RX_FIFO_IRQ_EN is defined.
module tb_uart_rx_fifo;
   logic clk;
   logic nrst;
   int   checks;
   int   failures;

   uart_rx_fifo_if #(.DEPTH(16), .WIDTH(8)) bus ();

   uart_rx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
   task automatic applyStimulus(input logic done, input logic [7:0] data, input logic rd,
                                input logic fl, input logic oc);
      bus.rx_done = done;
      bus.rx_data = data;
      bus.rd_en   = rd;
      bus.flush   = fl;
      bus.ovr_clr = oc;
      @(posedge clk);
      #1;
      bus.rx_done = 1'b0;
      bus.rx_data = 8'h00;
      bus.rd_en   = 1'b0;
      bus.flush   = 1'b0;
      bus.ovr_clr = 1'b0;
   endtask

   initial begin
      logic [7:0] model_q[$];
      logic [7:0] d;
      checks   = 0;
      failures = 0;
      nrst     = 1'b0;
      bus.rx_done = 1'b0;
      bus.rx_data = 8'h00;
      bus.rd_en   = 1'b0;
      bus.flush   = 1'b0;
      bus.ovr_clr = 1'b0;
`ifdef UART_RX_FIFO_IRQ_EN
      bus.irq_thresh = 5'd4;
`endif
      #23;
      checkOutput("rst_empty",   32'(bus.empty),   32'd1);
      checkOutput("rst_full",    32'(bus.full),    32'd0);
      checkOutput("rst_count",   32'(bus.count),   32'd0);
      checkOutput("rst_rd_data", 32'(bus.rd_data), 32'h0);
      checkOutput("rst_overrun", 32'(bus.overrun), 32'd0);
`ifdef UART_RX_FIFO_IRQ_EN
      checkOutput("rst_irq",     32'(bus.irq),     32'd0);
`endif
      @(posedge clk);
      #1;
      nrst = 1'b1;

      // Basic push of three bytes, FWFT head visible one cycle after the first push
      applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
      checkOutput("push1_rd_data", 32'(bus.rd_data), 32'h41);
      checkOutput("push1_empty",   32'(bus.empty),   32'd0);
      applyStimulus(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
      checkOutput("push3_count",   32'(bus.count),   32'd3);
      checkOutput("push3_rd_data", 32'(bus.rd_data), 32'h41);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("pop1_rd_data",  32'(bus.rd_data), 32'h42);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("pop2_rd_data",  32'(bus.rd_data), 32'h43);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("pop3_empty",    32'(bus.empty),   32'd1);
      checkOutput("pop3_rd_data",  32'(bus.rd_data), 32'h0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("pop_empty_count",   32'(bus.count),   32'd0);
      checkOutput("pop_empty_overrun", 32'(bus.overrun), 32'd0);

      // Fill to full, then drop 0xFF
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      end
      checkOutput("fill_full",  32'(bus.full),  32'd1);
      checkOutput("fill_count", 32'(bus.count), 32'd16);
      applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      checkOutput("drop_overrun", 32'(bus.overrun), 32'd1);
      checkOutput("drop_count",   32'(bus.count),   32'd16);
      checkOutput("drop_rd_data", 32'(bus.rd_data), 32'h00);

      // Clear coincident with a new drop: set wins
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
      checkOutput("clr_vs_set_overrun", 32'(bus.overrun), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checkOutput("clr_overrun", 32'(bus.overrun), 32'd0);

      // Full FIFO, push and pop together
      applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
      checkOutput("full_pp_count",   32'(bus.count),   32'd16);
      checkOutput("full_pp_overrun", 32'(bus.overrun), 32'd0);
      checkOutput("full_pp_rd_data", 32'(bus.rd_data), 32'h01);
      for (int i = 1; i < 16; i++) begin
         checkOutput($sformatf("drain_%0d", i), 32'(bus.rd_data), 32'(i));
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("drain_aa_rd_data", 32'(bus.rd_data), 32'hAA);
      checkOutput("drain_aa_count",   32'(bus.count),   32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("drain_empty", 32'(bus.empty), 32'd1);

      // Empty FIFO, push and pop together
      applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      checkOutput("empty_pp_count",   32'(bus.count),   32'd1);
      checkOutput("empty_pp_rd_data", 32'(bus.rd_data), 32'h55);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Pointer wrap with interleaved push/pop pairs against a queue model
      for (int i = 0; i < 40; i++) begin
         d = 8'((i * 37 + 11) & 8'hFF);
         model_q.push_back(d);
         applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("wrap_data_%0d", i), 32'(bus.rd_data), 32'(model_q[0]));
         void'(model_q.pop_front());
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         checkOutput($sformatf("wrap_count_%0d", i), 32'(bus.count), 32'(model_q.size()));
      end

      // Flush leaves overrun untouched and discards a same-cycle byte silently
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
      end
      checkOutput("ovr2_overrun", 32'(bus.overrun), 32'd1);
      applyStimulus(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
      checkOutput("flush_full_count",   32'(bus.count),   32'd0);
      checkOutput("flush_full_overrun", 32'(bus.overrun), 32'd1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
      end
      checkOutput("pre_flush5_count",   32'(bus.count),   32'd5);
      checkOutput("pre_flush5_rd_data", 32'(bus.rd_data), 32'hC0);
      applyStimulus(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
      checkOutput("flush5_count",   32'(bus.count),   32'd0);
      checkOutput("flush5_empty",   32'(bus.empty),   32'd1);
      checkOutput("flush5_rd_data", 32'(bus.rd_data), 32'h0);
      checkOutput("flush5_overrun", 32'(bus.overrun), 32'd1);
      applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
      checkOutput("post_flush_rd_data", 32'(bus.rd_data), 32'h3C);
      checkOutput("post_flush_overrun", 32'(bus.overrun), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("post_flush_empty", 32'(bus.empty), 32'd1);

`ifdef UART_RX_FIFO_IRQ_EN
      bus.irq_thresh = 5'd4;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      end
      checkOutput("irq_below_thresh", 32'(bus.irq), 32'd0);
      applyStimulus(1'b1, 8'h13, 1'b0, 1'b0, 1'b0);
      checkOutput("irq_at_thresh",       32'(bus.irq),   32'd1);
      checkOutput("irq_at_thresh_count", 32'(bus.count), 32'd4);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("irq_after_pop", 32'(bus.irq), 32'd0);
      bus.irq_thresh = 5'd0;
      applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
      checkOutput("irq_thresh0_no_ovr", 32'(bus.irq), 32'd0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 8'(8'h21 + i), 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
      checkOutput("irq_thresh0_ovr_overrun", 32'(bus.overrun), 32'd1);
      checkOutput("irq_thresh0_ovr",         32'(bus.irq),     32'd1);
`endif

      // Asynchronous reset while holding data
      applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h5B, 1'b0, 1'b0, 1'b0);
      #2;
      nrst = 1'b0;
      #1;
      checkOutput("mid_rst_count",   32'(bus.count),   32'd0);
      checkOutput("mid_rst_empty",   32'(bus.empty),   32'd1);
      checkOutput("mid_rst_rd_data", 32'(bus.rd_data), 32'h0);
      checkOutput("mid_rst_overrun", 32'(bus.overrun), 32'd0);
`ifdef UART_RX_FIFO_IRQ_EN
      checkOutput("mid_rst_irq",     32'(bus.irq),     32'd0);
`endif
      @(posedge clk);
      #1;
      nrst = 1'b1;
      applyStimulus(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
      checkOutput("after_rst_rd_data", 32'(bus.rd_data), 32'h66);
      checkOutput("after_rst_count",   32'(bus.count),   32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each completed byte on the receiver's done strobe into a circular FIFO.
- Presents the oldest byte first-word-fall-through to the CPU-side peripheral register logic.
- Tracks occupancy and flags overruns when a byte arrives with no free slot.

Parameters:
DEPTH, 16, number of byte entries; power of 2, minimum 2
WIDTH, 8, data width per entry
ADDR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
nrst  input  1  reset, asynchronous assert, active-low
rx_data  input  WIDTH  byte from receiver, valid when rx_done=1
rx_done  input  1  single-cycle strobe: push rx_data
rd_en  input  1  pop head entry (consumer acknowledge)
flush  input  1  synchronous clear of FIFO contents
ovr_clr  input  1  clear sticky overrun flag
rd_data  output  WIDTH  head entry (FWFT); 0 when empty
empty  output  1  count == 0
full  output  1  count == DEPTH
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overrun  output  1  sticky: a byte was dropped

Behaviour:
- Reset (nrst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, overrun=0, irq=0. Outputs: empty=1, full=0, rd_data=0. The storage array is not reset.
- Single clock domain; all state updates on posedge clk; empty, full and rd_data are derived combinationally from registered state.
- Push: rx_done=1 and (!full or pop this cycle) writes mem[wr_ptr]; wr_ptr increments modulo DEPTH (natural wrap, ADDR_W bits).
- Pop: rd_en=1 and !empty advances rd_ptr modulo DEPTH.
- rd_en while empty: ignored, no pointer or count change, no error flag.
- Latency: a byte pushed in cycle N appears on rd_data and clears empty in cycle N+1. A pop in cycle N exposes the next entry in cycle N+1.
- count: +1 on push only, -1 on pop only, unchanged on push+pop or on neither. Width ADDR_W+1, never exceeds DEPTH.
- Simultaneous push+pop when full: both accepted, count stays DEPTH, no overrun.
- Simultaneous push+pop when empty: push accepted, pop ignored, count becomes 1.
- Overrun: rx_done=1, full=1 and rd_en=0 drops rx_data (storage and pointers unchanged) and sets overrun=1 next cycle.
- overrun stays set until ovr_clr=1. If ovr_clr and a new overrun occur in the same cycle, set wins.
- flush=1: next cycle wr_ptr=rd_ptr=0, count=0. flush has priority over push and pop in the same cycle; a byte arriving that cycle is discarded without setting overrun. overrun is not affected by flush.
- rd_data = mem[rd_ptr] when !empty, else 0.
- Reset mid-operation: state returns immediately to reset values regardless of pending strobes.

Optional Feature:
- Macro UART_RX_FIFO_IRQ_EN.
- Defined: adds input irq_thresh [ADDR_W:0] and output irq (1 bit, registered, reset 0). Next-state irq = ((next count >= irq_thresh) and irq_thresh != 0) or next overrun, so irq updates in the same cycle as count.
- Undefined: neither port exists, no irq logic is generated; all other behaviour is identical.

Test Plan:
- Reset then push 0x41,0x42,0x43 on consecutive cycles -> count=3, rd_data=0x41 from the cycle after the first push; three pops return 0x41,0x42,0x43; then empty=1, rd_data=0.
- DEPTH=16: push 16 bytes 0x00..0x0F -> full=1, count=16; 17th push 0xFF -> overrun=1, count=16, pop sequence 0x00..0x0F with 0xFF absent.
- Full FIFO, rd_en and rx_done (0xAA) in the same cycle -> count stays 16, no overrun; after 15 further pops, rd_data=0xAA.
- Empty FIFO, rd_en and rx_done (0x55) in the same cycle -> count=1, rd_data=0x55; pointer wrap covered by 40 interleaved push/pop pairs with data checked against a model.
- Overrun set, then ovr_clr coincident with another dropped byte -> overrun remains 1; ovr_clr alone -> overrun=0. flush with count=5 -> count=0, empty=1, overrun unchanged.
- With UART_RX_FIFO_IRQ_EN, irq_thresh=4: push 3 bytes -> irq=0; 4th push -> irq=1 in the same cycle count reads 4; one pop -> irq=0; irq_thresh=0 with overrun=1 -> irq=1.
